dds_param_rx: RTL and testbench

//  DDS-side end of the REQ/ACK parameter handshake driven by the pulse-sequencer master.

---
 rtl/dds_param_rx_if.sv | 25 ++
 rtl/dds_param_rx.sv | 141 ++++++++++++++
 tb/tb_dds_param_rx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dds_param_rx_if.sv
// Parameter handshake and chirp-output bundle between the pulse-sequencer master
// and the DDS-side receiver.
interface dds_param_rx_if;
  logic        REQ;
  logic [47:0] DDS_freq;
  logic [47:0] DDS_delta_freq;
  logic [31:0] DDS_delta_rate;
  logic        DDS_start;
  logic        ACK;
  logic        PARAM_STB;
  logic        PARAM_VALID;
  logic        RUN;
  logic [47:0] FREQ_CUR;
  logic [47:0] PHASE_ACC;

  modport master (
    output REQ, DDS_freq, DDS_delta_freq, DDS_delta_rate, DDS_start,
    input  ACK, PARAM_STB, PARAM_VALID, RUN, FREQ_CUR, PHASE_ACC
  );

  modport slave (
    input  REQ, DDS_freq, DDS_delta_freq, DDS_delta_rate, DDS_start,
    output ACK, PARAM_STB, PARAM_VALID, RUN, FREQ_CUR, PHASE_ACC
  );
endinterface

// File: rtl/dds_param_rx.sv
// DDS-side receiver: synchronizes REQ/DDS_start, captures chirp parameters under a
// 4-phase handshake and runs the linear-FM frequency/phase accumulators.
module dds_param_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  dds_param_rx_if.slave  bus
);

  typedef enum logic {H_IDLE, H_WAIT} hs_state_t;

  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] start_sync;
  logic                   req_s;
  logic                   start_s;
  logic                   start_d;
  logic                   start_rise;
  logic                   start_fall;

  hs_state_t   state;
  hs_state_t   state_next;
  logic        capture;
  logic        ack_next;

  logic        ack;
  logic        param_stb;
  logic        param_valid;
  logic [47:0] sh_freq;
  logic [47:0] sh_dfreq;
  logic [31:0] sh_rate;

  logic        run;
  logic [47:0] freq_cur;
  logic [47:0] phase_acc;
  logic [47:0] act_dfreq;
  logic [31:0] act_rate;
  logic [31:0] rate_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_sync   <= '0;
      start_sync <= '0;
      start_d    <= 1'b0;
    end else begin
      req_sync   <= {req_sync[SYNC_STAGES-2:0], bus.REQ};
      start_sync <= {start_sync[SYNC_STAGES-2:0], bus.DDS_start};
      start_d    <= start_s;
    end
  end

  assign req_s      = req_sync[SYNC_STAGES-1];
  assign start_s    = start_sync[SYNC_STAGES-1];
  assign start_rise = start_s & ~start_d;
  assign start_fall = ~start_s & start_d;

  always_ff @(posedge CLK) begin
    if (RESET) state <= H_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      H_IDLE:  if (req_s)  state_next = H_WAIT;
      H_WAIT:  if (!req_s) state_next = H_IDLE;
      default: state_next = H_IDLE;
    endcase
  end

  always_comb begin
    capture  = 1'b0;
    ack_next = 1'b0;
    case (state)
      H_IDLE: begin
        capture  = req_s;
        ack_next = req_s;
      end
      H_WAIT:  ack_next = req_s;
      default: ack_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ack         <= 1'b0;
      param_stb   <= 1'b0;
      param_valid <= 1'b0;
      sh_freq     <= '0;
      sh_dfreq    <= '0;
      sh_rate     <= '0;
    end else begin
      ack       <= ack_next;
      param_stb <= capture;
      if (capture) begin
        param_valid <= 1'b1;
        sh_freq     <= bus.DDS_freq;
        sh_dfreq    <= bus.DDS_delta_freq;
        sh_rate     <= bus.DDS_delta_rate;
      end
    end
  end

  // Reads the shadows as registered, so a capture in the start cycle only affects the next burst.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      run       <= 1'b0;
      freq_cur  <= '0;
      phase_acc <= '0;
      act_dfreq <= '0;
      act_rate  <= '0;
      rate_cnt  <= '0;
    end else if (start_rise && param_valid) begin
      run       <= 1'b1;
      freq_cur  <= sh_freq;
      act_dfreq <= sh_dfreq;
      act_rate  <= sh_rate;
      rate_cnt  <= '0;
      phase_acc <= '0;
    end else if (start_fall) begin
      run       <= 1'b0;
      phase_acc <= '0;
    end else if (run) begin
      phase_acc <= phase_acc + freq_cur;
      if (rate_cnt == act_rate) begin
        rate_cnt <= '0;
        freq_cur <= freq_cur + act_dfreq;
      end else begin
        rate_cnt <= rate_cnt + 32'd1;
      end
    end
  end

  assign bus.ACK         = ack;
  assign bus.PARAM_STB   = param_stb;
  assign bus.PARAM_VALID = param_valid;
  assign bus.RUN         = run;
  assign bus.FREQ_CUR    = freq_cur;
  assign bus.PHASE_ACC   = phase_acc;

endmodule

// File: tb/tb_dds_param_rx.sv
// Randomized and directed bench for dds_param_rx; a closed-form chirp model
// (frequency as a function of cycles since start) predicts every output each cycle.
module tb_dds_param_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dds_param_rx_if bus ();

  dds_param_rx #(.SYNC_STAGES(2)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        m_run = 1'b0, m_ack = 1'b0, m_stb = 1'b0, m_valid = 1'b0, m_busy = 1'b0;
  logic [47:0] m_freq = '0, m_phase = '0, m_shf = '0, m_shd = '0, m_cf = '0, m_cd = '0;
  logic [31:0] m_shr = '0, m_cr = '0;
  longint unsigned m_n = 0;
  logic rq_p1 = 1'b0, rq_p2 = 1'b0, st_p1 = 1'b0, st_p2 = 1'b0, st_p3 = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Frequency after n accumulation cycles: one step per (rate+1) cycles.
  function automatic logic [47:0] freq_at(input logic [47:0] f, input logic [47:0] d,
                                          input logic [31:0] r, input longint unsigned n);
    logic [63:0] steps;
    steps = n / ({32'd0, r} + 64'd1);
    return f + d * steps[47:0];
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[47:0];
  endfunction

  task automatic model_edge();
    logic req_s, st_s, st_d;
    if (rst) begin
      m_run = 0; m_ack = 0; m_stb = 0; m_valid = 0; m_busy = 0;
      m_freq = '0; m_phase = '0; m_shf = '0; m_shd = '0; m_shr = '0;
      m_cf = '0; m_cd = '0; m_cr = '0; m_n = 0;
      rq_p1 = 0; rq_p2 = 0; st_p1 = 0; st_p2 = 0; st_p3 = 0;
    end else begin
      req_s = rq_p2;
      st_s  = st_p2;
      st_d  = st_p3;
      if (st_s && !st_d && m_valid) begin
        m_run = 1; m_cf = m_shf; m_cd = m_shd; m_cr = m_shr;
        m_n = 0; m_phase = '0; m_freq = m_shf;
      end else if (!st_s && st_d) begin
        m_run = 0; m_phase = '0;
      end else if (m_run) begin
        m_phase = m_phase + freq_at(m_cf, m_cd, m_cr, m_n);
        m_n++;
        m_freq = freq_at(m_cf, m_cd, m_cr, m_n);
      end
      m_stb = 0;
      if (!m_busy && req_s) begin
        m_shf = bus.DDS_freq; m_shd = bus.DDS_delta_freq; m_shr = bus.DDS_delta_rate;
        m_stb = 1; m_valid = 1; m_ack = 1; m_busy = 1;
      end else if (m_busy && !req_s) begin
        m_ack = 0; m_busy = 0;
      end
      st_p3 = st_p2; st_p2 = st_p1; st_p1 = bus.DDS_start;
      rq_p2 = rq_p1; rq_p1 = bus.REQ;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("ack",   {63'd0, bus.ACK},         {63'd0, m_ack});
    checkOutput("stb",   {63'd0, bus.PARAM_STB},   {63'd0, m_stb});
    checkOutput("valid", {63'd0, bus.PARAM_VALID}, {63'd0, m_valid});
    checkOutput("run",   {63'd0, bus.RUN},         {63'd0, m_run});
    checkOutput("freq",  {16'd0, bus.FREQ_CUR},    {16'd0, m_freq});
    checkOutput("phase", {16'd0, bus.PHASE_ACC},   {16'd0, m_phase});
  endtask

  task automatic applyStimulus(input logic req, input logic start, input logic [47:0] f,
                               input logic [47:0] d, input logic [31:0] r);
    bus.REQ            = req;
    bus.DDS_start      = start;
    bus.DDS_freq       = f;
    bus.DDS_delta_freq = d;
    bus.DDS_delta_rate = r;
  endtask

  task automatic run_handshake(input logic [47:0] f, input logic [47:0] d, input logic [31:0] r);
    applyStimulus(1'b1, bus.DDS_start, f, d, r);
    repeat (2) tick();
    checkOutput("ack_before_sync", {63'd0, bus.ACK}, 64'd0);
    tick();
    checkOutput("ack_rise", {63'd0, bus.ACK}, 64'd1);
    checkOutput("stb_pulse", {63'd0, bus.PARAM_STB}, 64'd1);
    tick();
    checkOutput("stb_drop", {63'd0, bus.PARAM_STB}, 64'd0);
    applyStimulus(1'b0, bus.DDS_start, f, d, r);
    repeat (2) tick();
    checkOutput("ack_hold", {63'd0, bus.ACK}, 64'd1);
    tick();
    checkOutput("ack_fall", {63'd0, bus.ACK}, 64'd0);
  endtask

  task automatic set_start(input logic start);
    bus.DDS_start = start;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("reset_run", {63'd0, bus.RUN}, 64'd0);
    checkOutput("reset_phase", {16'd0, bus.PHASE_ACC}, 64'd0);
    #1 rst = 1'b0;

    // Start before any parameter set: ignored.
    set_start(1'b1);
    repeat (6) tick();
    checkOutput("no_param_run", {63'd0, bus.RUN}, 64'd0);
    set_start(1'b0);
    repeat (4) tick();

    run_handshake(48'h1000, 48'h10, 32'd3);
    checkOutput("valid_after_hs", {63'd0, bus.PARAM_VALID}, 64'd1);

    set_start(1'b1);
    repeat (3) tick();
    checkOutput("t2_run", {63'd0, bus.RUN}, 64'd1);
    checkOutput("t2_freq0", {16'd0, bus.FREQ_CUR}, 64'h1000);
    repeat (4) tick();
    checkOutput("t2_freq_step", {16'd0, bus.FREQ_CUR}, 64'h1010);
    repeat (8) tick();
    set_start(1'b0);
    repeat (4) tick();

    run_handshake(48'hFFFF_FFFF_FFF0, 48'h20, 32'd0);
    set_start(1'b1);
    repeat (4) tick();
    checkOutput("t3_freq_wrap", {16'd0, bus.FREQ_CUR}, 64'h10);
    tick();
    checkOutput("t3_phase_wrap", {16'd0, bus.PHASE_ACC}, 64'h0);
    repeat (6) tick();
    set_start(1'b0);
    repeat (4) tick();

    // New handshake mid-burst must not disturb the running chirp.
    run_handshake(48'h3000, 48'h5, 32'd2);
    set_start(1'b1);
    repeat (5) tick();
    run_handshake(48'h2000, 48'h7, 32'd1);
    checkOutput("t4_run_kept", {63'd0, bus.RUN}, 64'd1);
    set_start(1'b0);
    repeat (4) tick();
    set_start(1'b1);
    repeat (3) tick();
    checkOutput("t4_new_freq", {16'd0, bus.FREQ_CUR}, 64'h2000);
    set_start(1'b0);
    repeat (4) tick();

    // Capture and start edge land on the same clock.
    applyStimulus(1'b1, 1'b1, 48'h4000, 48'h3, 32'd0);
    repeat (3) tick();
    checkOutput("t5_old_freq", {16'd0, bus.FREQ_CUR}, 64'h2000);
    checkOutput("t5_stb", {63'd0, bus.PARAM_STB}, 64'd1);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b1, 48'h4000, 48'h3, 32'd0);
    repeat (4) tick();
    set_start(1'b0);
    repeat (4) tick();
    set_start(1'b1);
    repeat (3) tick();
    checkOutput("t5_new_freq", {16'd0, bus.FREQ_CUR}, 64'h4000);
    set_start(1'b0);
    repeat (4) tick();

    // Reset while waiting in the handshake with a chirp running.
    applyStimulus(1'b1, 1'b0, 48'h5000, 48'h1, 32'd1);
    repeat (4) tick();
    set_start(1'b1);
    repeat (5) tick();
    checkOutput("t6_running", {63'd0, bus.RUN}, 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("t6_rst_run", {63'd0, bus.RUN}, 64'd0);
    checkOutput("t6_rst_ack", {63'd0, bus.ACK}, 64'd0);
    checkOutput("t6_rst_freq", {16'd0, bus.FREQ_CUR}, 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    checkOutput("t6_ack_wait", {63'd0, bus.ACK}, 64'd0);
    tick();
    checkOutput("t6_ack_again", {63'd0, bus.ACK}, 64'd1);
    bus.REQ = 1'b0;
    repeat (4) tick();
    set_start(1'b0);
    repeat (4) tick();

    // Maximum rate period: frequency holds over the observed window.
    run_handshake(rand48(), rand48(), 32'hFFFF_FFFF);
    set_start(1'b1);
    repeat (12) tick();
    set_start(1'b0);
    repeat (4) tick();

    for (int i = 0; i < 8; i++) begin
      run_handshake(rand48(), rand48(), 32'($urandom_range(0, 5)));
      set_start(1'b1);
      repeat ($urandom_range(4, 20)) tick();
      if ($urandom_range(0, 1) == 1) run_handshake(rand48(), rand48(), 32'($urandom_range(0, 5)));
      repeat ($urandom_range(1, 6)) tick();
      set_start(1'b0);
      repeat ($urandom_range(4, 8)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
